// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the memory stage and a valid/ready main-memory port with a separate response channel.
module data_cache #(
  parameter int WIDTH = 32,
  parameter int SETS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             stall,
  output logic             mem_req_valid,
  output logic             mem_req_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = WIDTH - IDX - 2;

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_WAIT,
    WRITE_REQ,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [TAGW-1:0]  tag_q  [SETS];
  logic [WIDTH-1:0] data_q [SETS];

  logic [IDX-1:0]  index;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            fill;
  logic            write_hit;

  assign index = addr[IDX+1:2];
  assign tag   = addr[WIDTH-1:IDX+2];
  assign hit   = valid_q[index] && (tag_q[index] == tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone decide whether a line counts.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_rdata;
    end else if (write_hit) begin
      data_q[index] <= wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    resp_d        = resp_q;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    fill          = 1'b0;
    write_hit     = 1'b0;
    rdata         = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            stall   = 1'b1;
            state_d = WRITE_REQ;
          end else if (hit) begin
            rdata = data_q[index];
          end else begin
            stall   = 1'b1;
            state_d = READ_REQ;
          end
        end
      end
      READ_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = READ_WAIT;
      end
      READ_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          fill           = 1'b1;
          valid_d[index] = 1'b1;
          resp_d         = mem_rdata;
          state_d        = RESP;
        end
      end
      WRITE_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        if (mem_req_ready) begin
          write_hit = hit;
          state_d   = RESP;
        end
      end
      RESP: begin
        // The core advances on this edge, so the request is released before IDLE sees it.
        if (req_valid && !req_write) rdata = resp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = req_valid ? (addr & ~WIDTH'(3)) : '0;
  assign mem_wdata = req_valid ? wdata : '0;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: the bench plays main memory with scripted
// ready/response delays and checks stall counts, returned data and requests.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        memReqValid;
  logic        memReqWrite;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memReqReady;
  logic        memRespValid;
  logic [31:0] memRdata;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  data_cache #(.WIDTH(32), .SETS(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (reqValid),
    .req_write      (reqWrite),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .stall          (stall),
    .mem_req_valid  (memReqValid),
    .mem_req_write  (memReqWrite),
    .mem_addr       (memAddr),
    .mem_wdata      (memWdata),
    .mem_req_ready  (memReqReady),
    .mem_resp_valid (memRespValid),
    .mem_rdata      (memRdata)
  );

  // Drives one access from posedge+1 until the cycle stall drops, acting as main memory.
  task automatic run_access(
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  int          readyDelay,
    input  int          respDelay,
    input  logic [31:0] memData,
    output int          stallCycles,
    output logic [31:0] rdOut,
    output logic        sawReq,
    output logic [31:0] reqAddr,
    output logic        obsWrite,
    output logic [31:0] reqWdata,
    output logic        stable
  );
    int   reqCycles;
    int   waitCycles;
    logic handshook;
    logic finished;
    stallCycles = 0; rdOut = '0; sawReq = 1'b0; reqAddr = '0; obsWrite = 1'b0;
    reqWdata = '0; stable = 1'b1;
    reqCycles = 0; waitCycles = 0; handshook = 1'b0; finished = 1'b0;
    reqValid = 1'b1; reqWrite = wr; addr = a; wdata = wd;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      #1;
      if (!stall) begin
        rdOut    = rdata;
        finished = 1'b1;
      end else begin
        stallCycles++;
        if (memReqValid) begin
          if (!sawReq) begin
            sawReq = 1'b1; reqAddr = memAddr; obsWrite = memReqWrite; reqWdata = memWdata;
          end else if (memAddr !== reqAddr || memReqWrite !== obsWrite || memWdata !== reqWdata) begin
            stable = 1'b0;
          end
          reqCycles++;
          memReqReady = (reqCycles > readyDelay);
          if (memReqReady) handshook = 1'b1;
        end else if (handshook && !wr) begin
          waitCycles++;
          memRespValid = (waitCycles >= respDelay);
          memRdata     = memData;
        end
      end
      @(posedge clk); #1;
      memReqReady = 1'b0; memRespValid = 1'b0;
    end
    reqValid = 1'b0; reqWrite = 1'b0; addr = '0; wdata = '0;
    assertCount++;
    if (!finished) begin
      failCount++;
      $display("[TB] FAIL access_timeout: addr=%h never completed, stall still %b", a, stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; addr = '0; wdata = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRdata = '0;
    #12;
    assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    assertCount++; if (memReqValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_req_valid: got %b expected 0", memReqValid); end
    assertCount++; if (rdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    assertCount++; if (memAddr !== 32'h0 || memWdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_mem_bus: got addr %h wdata %h expected 0 0", memAddr, memWdata); end
    reqValid = 1'b1; addr = 32'h40; #1;
    assertCount++; if (stall !== 1'b1) begin failCount++; $display("[TB] FAIL reset_miss_stall: got %b expected 1", stall); end
    reqValid = 1'b0; addr = '0;
    #3; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss_hit();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    run_access(1'b0, 32'h40, 32'h0, 0, 1, 32'hDEAD_BEEF, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3) begin failCount++; $display("[TB] FAIL miss_stalls: got %0d expected 3", sc); end
    assertCount++; if (rd !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL miss_rdata: got %h expected deadbeef", rd); end
    assertCount++; if (saw !== 1'b1 || ra !== 32'h40 || rw !== 1'b0) begin failCount++; $display("[TB] FAIL miss_request: got req %b addr %h write %b expected 1 00000040 0", saw, ra, rw); end
    run_access(1'b0, 32'h40, 32'h0, 0, 1, 32'h0, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 0) begin failCount++; $display("[TB] FAIL hit_stalls: got %0d expected 0", sc); end
    assertCount++; if (rd !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL hit_rdata: got %h expected deadbeef", rd); end
    assertCount++; if (saw !== 1'b0) begin failCount++; $display("[TB] FAIL hit_no_request: got %b expected 0", saw); end
  endtask

  task automatic test_store_hit();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    run_access(1'b1, 32'h40, 32'h1234_5678, 0, 1, 32'h0, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 2) begin failCount++; $display("[TB] FAIL store_stalls: got %0d expected 2", sc); end
    assertCount++; if (saw !== 1'b1 || rw !== 1'b1 || ra !== 32'h40 || rwd !== 32'h1234_5678) begin failCount++; $display("[TB] FAIL store_request: got req %b write %b addr %h data %h expected 1 1 00000040 12345678", saw, rw, ra, rwd); end
    run_access(1'b0, 32'h40, 32'h0, 0, 1, 32'hFFFF_FFFF, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 0 || saw !== 1'b0) begin failCount++; $display("[TB] FAIL store_then_hit: got stalls %0d req %b expected 0 0", sc, saw); end
    assertCount++; if (rd !== 32'h1234_5678) begin failCount++; $display("[TB] FAIL store_then_rdata: got %h expected 12345678", rd); end
  endtask

  task automatic test_store_no_allocate();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    run_access(1'b1, 32'h80, 32'hAAAA_5555, 0, 1, 32'h0, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 2 || ra !== 32'h80) begin failCount++; $display("[TB] FAIL nalloc_store: got stalls %0d addr %h expected 2 00000080", sc, ra); end
    run_access(1'b0, 32'h83, 32'h0, 0, 1, 32'hCAFE_F00D, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || saw !== 1'b1) begin failCount++; $display("[TB] FAIL nalloc_load_miss: got stalls %0d req %b expected 3 1", sc, saw); end
    assertCount++; if (ra !== 32'h80 || rw !== 1'b0) begin failCount++; $display("[TB] FAIL nalloc_aligned_addr: got addr %h write %b expected 00000080 0", ra, rw); end
    assertCount++; if (rd !== 32'hCAFE_F00D) begin failCount++; $display("[TB] FAIL nalloc_rdata: got %h expected cafef00d", rd); end
  endtask

  task automatic test_conflict();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    run_access(1'b0, 32'h40, 32'h0, 0, 1, 32'h1111_2222, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || rd !== 32'h1111_2222) begin failCount++; $display("[TB] FAIL conflict_evict_40: got stalls %0d data %h expected 3 11112222", sc, rd); end
    run_access(1'b0, 32'h80, 32'h0, 0, 1, 32'hCAFE_F00D, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || ra !== 32'h80) begin failCount++; $display("[TB] FAIL conflict_evict_80: got stalls %0d addr %h expected 3 00000080", sc, ra); end
    run_access(1'b0, 32'h40, 32'h0, 0, 1, 32'h1111_2222, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || saw !== 1'b1 || rd !== 32'h1111_2222) begin failCount++; $display("[TB] FAIL conflict_reload: got stalls %0d req %b data %h expected 3 1 11112222", sc, saw, rd); end
  endtask

  task automatic test_stall_delays();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    run_access(1'b0, 32'hC4, 32'h0, 4, 3, 32'h0BAD_CAFE, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 9) begin failCount++; $display("[TB] FAIL delay_load_stalls: got %0d expected 9", sc); end
    assertCount++; if (st !== 1'b1 || ra !== 32'hC4) begin failCount++; $display("[TB] FAIL delay_load_stable: got stable %b addr %h expected 1 000000c4", st, ra); end
    assertCount++; if (rd !== 32'h0BAD_CAFE) begin failCount++; $display("[TB] FAIL delay_load_rdata: got %h expected 0badcafe", rd); end
    run_access(1'b1, 32'hC4, 32'h5A5A_5A5A, 2, 1, 32'h0, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 4 || st !== 1'b1) begin failCount++; $display("[TB] FAIL delay_store: got stalls %0d stable %b expected 4 1", sc, st); end
  endtask

  task automatic test_back_to_back();
    reqValid = 1'b1; reqWrite = 1'b0; addr = 32'h42; #1;
    assertCount++; if (stall !== 1'b0 || rdata !== 32'h1111_2222) begin failCount++; $display("[TB] FAIL b2b_first: got stall %b data %h expected 0 11112222", stall, rdata); end
    @(posedge clk); #1;
    addr = 32'hC4; #1;
    assertCount++; if (stall !== 1'b0 || rdata !== 32'h5A5A_5A5A) begin failCount++; $display("[TB] FAIL b2b_second: got stall %b data %h expected 0 5a5a5a5a", stall, rdata); end
    @(posedge clk); #1;
    reqValid = 1'b0; addr = '0; #1;
    assertCount++; if (rdata !== 32'h0 || memAddr !== 32'h0) begin failCount++; $display("[TB] FAIL idle_outputs: got rdata %h addr %h expected 0 0", rdata, memAddr); end
  endtask

  task automatic test_reset_mid();
    int sc; logic [31:0] rd, ra, rwd; logic saw, rw, st;
    reqValid = 1'b1; reqWrite = 1'b0; addr = 32'h48;
    @(posedge clk); #1;
    memReqReady = 1'b1;
    @(posedge clk); #1;
    memReqReady = 1'b0;
    #1; rst = 1'b0; reqValid = 1'b0; addr = '0; #1;
    assertCount++; if (memReqValid !== 1'b0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_idle: got req %b stall %b expected 0 0", memReqValid, stall); end
    @(posedge clk); #3; rst = 1'b1;
    @(posedge clk); #1;
    memRespValid = 1'b1; memRdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    memRespValid = 1'b0;
    assertCount++; if (memReqValid !== 1'b0 || stall !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_late_resp: got req %b stall %b expected 0 0", memReqValid, stall); end
    run_access(1'b0, 32'h48, 32'h0, 0, 1, 32'h600D_F00D, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || rd !== 32'h600D_F00D) begin failCount++; $display("[TB] FAIL midreset_reload: got stalls %0d data %h expected 3 600df00d", sc, rd); end
    run_access(1'b0, 32'hC4, 32'h0, 0, 1, 32'h7777_8888, sc, rd, saw, ra, rw, rwd, st);
    assertCount++; if (sc !== 3 || rd !== 32'h7777_8888) begin failCount++; $display("[TB] FAIL midreset_invalidated: got stalls %0d data %h expected 3 77778888", sc, rd); end
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store_hit();
    test_store_no_allocate();
    test_conflict();
    test_stall_delays();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache. It responds to load/store requests from the memory stage of the pipelined core and initiates word transfers to main memory over a valid/ready request channel with a separate response channel. On a miss or a write it raises `stall`, which freezes the pipeline. The block replaces the direct data-memory connection in the memory stage.

## Interface
- `WIDTH`, 32: data and address width.
- `SETS`, 16: number of one-word lines; must be a power of 2 and ≥2. `IDX` = log2(SETS).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a memory-stage access is present.
- `req_write`  in  1  1 = store, 0 = load.
- `addr`  in  WIDTH  byte address; bits [1:0] are ignored (word access only).
- `wdata`  in  WIDTH  store data.
- `rdata`  out  WIDTH  load data; valid when `req_valid & !req_write & !stall`.
- `stall`  out  1  holds the pipeline; the core keeps every request input stable while this is high.
- `mem_req_valid`  out  1  request to main memory.
- `mem_req_write`  out  1  1 = write, 0 = read.
- `mem_addr`  out  WIDTH  word-aligned address, with bits [1:0] = 0.
- `mem_wdata`  out  WIDTH  write data.
- `mem_req_ready`  in  1  main memory accepts the request this cycle.
- `mem_resp_valid`  in  1  read data returned.
- `mem_rdata`  in  WIDTH  read data.

## Operation
- Address split: index = `addr[IDX+1:2]`, tag = `addr[WIDTH-1:IDX+2]`.
- Storage per line: valid bit, tag, data word.
  - Valid bits clear on reset.
  - Tag and data arrays have no reset.
- Hit = `valid[index] & (tag_array[index] == tag)`.
- FSM states: IDLE, READ_REQ, READ_WAIT, WRITE_REQ, RESP.
- IDLE
  - No request: `stall` = 0.
  - Load hit: `rdata` = line data (combinational), `stall` = 0, and the state stays IDLE.
  - Load miss: `stall` = 1, next state READ_REQ.
  - Store, hit or miss: `stall` = 1, next state WRITE_REQ.
- READ_REQ
  - Outputs: `mem_req_valid` = 1, `mem_req_write` = 0, `mem_addr` = {addr[WIDTH-1:2], 2'b00}.
  - Stays in READ_REQ until `mem_req_ready`, then goes to READ_WAIT.
- READ_WAIT
  - Waits for `mem_resp_valid`.
  - On response: write data, tag and valid=1 into the line at index, capture `mem_rdata` into a response register, go to RESP.
  - A response in the same cycle as the READ_REQ handshake is not accepted; the response must come at least one cycle after the handshake.
- WRITE_REQ
  - Outputs: `mem_req_valid` = 1, `mem_req_write` = 1, `mem_wdata` = `wdata`.
  - On `mem_req_ready`:
    - On a hit, update the line data with `wdata`.
    - On a miss, leave the cache unchanged (no allocate).
    - Go to RESP.
- RESP
  - `stall` = 0 for exactly one cycle.
  - For a load, `rdata` = response register.
  - Next state IDLE unconditionally; the core advances on this edge, so the same request is not seen again.
- `stall` = 1 in READ_REQ, READ_WAIT and WRITE_REQ.
- `mem_req_valid` is registered-state-driven (a function of state only). Once raised, it stays high with stable address and data until `mem_req_ready`.
- `mem_resp_valid` is ignored in every state except READ_WAIT.
- `mem_req_ready` is ignored when `mem_req_valid` = 0.

## Timing
- Reset values:
  - state IDLE and all valid bits 0.
  - `mem_req_valid` 0; `stall` 0 unless IDLE combinational logic sees a miss or store.
  - `rdata`, `mem_addr` and `mem_wdata` are don't-care but must not be X when `req_valid` is low. Drive 0 in that case.
- Load hit: 0 stall cycles.
- Load miss with ready and response both at the earliest point: 3 stall cycles, then RESP.
  - T0 IDLE, T1 READ_REQ (handshake), T2 READ_WAIT (response), T3 RESP.
- Store with ready in the first WRITE_REQ cycle: 2 stall cycles, then RESP.
- Each cycle of `mem_req_ready` low or response delay adds exactly one stall cycle.
- Reset asserted mid-transaction:
  - Immediate return to IDLE, `mem_req_valid` = 0, all lines invalid.
  - A late `mem_resp_valid` after reset is discarded.
- A line fill and a load of the same index resolve correctly: the RESP data is the filled word.

## Test plan
- Reset, then load 0x0000_0040 (memory holds 0xDEAD_BEEF): 3 stall cycles with immediate ready/response, `rdata` = 0xDEAD_BEEF in RESP. A repeat load hits with `stall` = 0 and the same data.
- Store 0x1234_5678 to 0x40 after it is cached: `mem_req_write` = 1 with `mem_addr` = 0x40. A later load hits and returns 0x1234_5678 with no memory request.
- Store to uncached 0x80, then load 0x80: the store causes no allocate, so the load misses and issues a read of 0x80.
- Conflict with SETS=16: load 0x40, then load 0x80 (same index 0, different tag). The second load misses and evicts; reloading 0x40 misses again.
- Hold `mem_req_ready` low 4 cycles, then send the response 3 cycles after the handshake: `stall` is high throughout, and `mem_addr` and `mem_req_valid` stay stable until accepted.
- Assert `rst` low during READ_WAIT, then pulse `mem_resp_valid` after release: FSM is IDLE, no line is written, and the next load to that address misses.
